// File: rtl/proc_pkg.sv
// Shared types and constants for the core's hazard/sequencing control.
//   fwd_sel_t    : EX operand source select driven into ID/EX
//   ctrl_state_t : controller sequencing state
//   inflight_t   : one shadow-pipeline slot (destination info only)
package proc_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;   // source operands per instruction (rn, rm)

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN,
    HALT
  } ctrl_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } inflight_t;

  // Slot produces the value a consumer wants to read.
  function automatic logic slot_hit(input inflight_t s, input logic [REG_AW-1:0] src);
    return s.valid & s.reg_write & (s.rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard interface.
//   master : decode stage / bench, drives ID instruction info and branch result
//   slave  : pipe_hazard_ctrl, drives pipeline enables, forwarding selects,
//            register-file clear port and halted
interface pipe_hazard_ctrl_if #(
  parameter int AW = proc_pkg::REG_AW
);
  logic          id_valid;
  logic [AW-1:0] id_rn;
  logic [AW-1:0] id_rm;
  logic          id_rn_used;
  logic          id_rm_used;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_is_load;
  logic          id_halt;
  logic          ex_branch_taken;

  logic          pc_en;
  logic          ifid_en;
  logic          ifid_flush;
  logic          idex_bubble;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic          halted;

  modport master (
    output id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
           id_reg_write, id_is_load, id_halt, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b,
           init_we, init_addr, halted
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd,
           id_reg_write, id_is_load, id_halt, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b,
           init_we, init_addr, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl_inflight_tracker.sv
// inflight_tracker: 3-slot shadow of EX/MEM/WB destinations plus per-operand
// producer matching.
//   clk, rst   : clock, async active-low reset (clears all slots)
//   capture    : ID instruction really enters ID/EX this cycle
//   id_info    : destination info of the ID instruction
//   src        : packed source register numbers, [0]=rn [1]=rm
//   src_used   : per-source "operand is actually read"
//   fwd        : per-source forwarding select
//   load_use   : some used source depends on a load sitting in EX
module inflight_tracker
  import proc_pkg::*;
#(
  parameter int NSRC = NUM_SRC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  inflight_t                   id_info,
  input  logic [NSRC-1:0][REG_AW-1:0] src,
  input  logic [NSRC-1:0]             src_used,
  output fwd_sel_t [NSRC-1:0]         fwd,
  output logic                        load_use
);

  localparam int EX = 0, MEM = 1, WB = 2;

  inflight_t [2:0] slot;
  logic [NSRC-1:0] lu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot <= '0;
    end else begin
      slot[EX]  <= capture ? id_info : '0;
      slot[MEM] <= slot[EX];
      slot[WB]  <= slot[MEM];
    end
  end

  // WB needs no forward (write-through register file) and MEM forwards the
  // MEM/WB result whether it came from ALU or RAM, so these fields are only
  // tracked for visibility in the shadow pipeline.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{slot[WB], slot[MEM].is_load};

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic ex_hit, mem_hit;
    assign ex_hit  = src_used[i] & slot_hit(slot[EX],  src[i]);
    assign mem_hit = src_used[i] & slot_hit(slot[MEM], src[i]);
    // Youngest producer first; a load in EX cannot forward yet (stall instead).
    assign fwd[i]  = (ex_hit & ~slot[EX].is_load) ? FWD_EXMEM :
                     mem_hit                      ? FWD_MEMWB : FWD_RF;
    assign lu[i]   = ex_hit & slot[EX].is_load;
  end

  assign load_use = |lu;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage core.
// Runs the power-up register-file clear, then drives forwarding selects,
// load-use stalls, taken-branch flushes and halt draining.
//   clk  : core clock
//   rst  : asynchronous reset, active-low
//   bus  : pipe_hazard_ctrl_if.slave (ID info in; PC/IF/ID/ID/EX controls,
//          forwarding selects, clear port and halted out)
// All outputs are combinational from state, shadow slots and ID inputs.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);
  import proc_pkg::*;

  // One counter serves both the clear sweep and the drain; DRAIN_CYCLES must
  // fit in REG_AW bits.
  localparam logic [REG_AW-1:0] INIT_LAST  = REG_AW'(NUM_REGS - 1);
  localparam logic [REG_AW-1:0] DRAIN_LAST = REG_AW'(DRAIN_CYCLES - 1);

  ctrl_state_t         state, state_nxt;
  logic [REG_AW-1:0]   cnt, cnt_nxt;

  fwd_sel_t [NUM_SRC-1:0] fwd;
  logic                   load_use;
  inflight_t              id_info;

  fwd_sel_t            fwd_a, fwd_b;
  logic                pc_en, ifid_en, ifid_flush, idex_bubble;
  logic                init_we, halted;
  logic [REG_AW-1:0]   init_addr;

  assign id_info = '{valid: 1'b1, rd: bus.id_rd,
                     reg_write: bus.id_reg_write, is_load: bus.id_is_load};

  inflight_tracker #(.NSRC(NUM_SRC)) u_trk (
    .clk      (clk),
    .rst      (rst),
    .capture  (bus.id_valid & ~idex_bubble),
    .id_info  (id_info),
    .src      ({bus.id_rm, bus.id_rn}),
    .src_used ({bus.id_rm_used, bus.id_rn_used}),
    .fwd      (fwd),
    .load_use (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    init_we     = 1'b0;
    init_addr   = '0;
    halted      = 1'b0;

    case (state)
      INIT: begin
        init_we   = 1'b1;
        init_addr = cnt;
        if (cnt == INIT_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      RUN: begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
        fwd_a       = fwd[0];
        fwd_b       = fwd[1];
        if (bus.ex_branch_taken) begin
          // Squash the two younger instructions; this also swallows any
          // load-use stall or halt sitting in ID.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (bus.id_valid && bus.id_halt) begin
          // HALT itself becomes a bubble; fetch stops from the next cycle.
          idex_bubble = 1'b1;
          state_nxt   = DRAIN;
          cnt_nxt     = '0;
        end
      end

      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = HALT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      HALT: halted = 1'b1;

      default: state_nxt = INIT;
    endcase
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.init_we     = init_we;
  assign bus.init_addr   = init_addr;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per cycle, drive ID inputs, queue the expected
// controller outputs, and check them on the falling edge.
module tb_pipe_hazard_ctrl;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.AW(REG_AW)) bus ();

  pipe_hazard_ctrl #(
    .NUM_REGS     (NUM_REGS),
    .REG_AW       (REG_AW),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       pc_en, ifid_en, flush, bubble;
    logic [1:0] fa, fb;
    logic       we;
    logic [4:0] addr;
    logic       halted;
  } exp_t;

  typedef struct packed {
    logic       rst, valid;
    logic [4:0] rd;
    logic       rw, load;
    logic [4:0] rn;
    logic       rnu;
    logic [4:0] rm;
    logic       rmu;
    logic       halt, br;
  } stim_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t e_run(input logic pc, ifid, fl, bub, input logic [1:0] fa, fb);
    exp_t e = '0;
    e.pc_en = pc; e.ifid_en = ifid; e.flush = fl; e.bubble = bub; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  function automatic exp_t e_init(input int k);
    exp_t e = '0;
    e.bubble = 1'b1; e.we = 1'b1; e.addr = 5'(k);
    return e;
  endfunction

  function automatic exp_t e_stop(input logic h);
    exp_t e = '0;
    e.bubble = 1'b1; e.halted = h;
    return e;
  endfunction

  function automatic stim_t ins(input logic [4:0] rd, input logic rw, ld,
                                input logic [4:0] rn, input logic rnu,
                                input logic [4:0] rm, input logic rmu);
    stim_t s = '0;
    s.rst = 1'b1; s.valid = 1'b1; s.rd = rd; s.rw = rw; s.load = ld;
    s.rn = rn; s.rnu = rnu; s.rm = rm; s.rmu = rmu;
    return s;
  endfunction

  function automatic stim_t nop();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic step(input string tag, input stim_t s, input exp_t e);
    exp_t got, want;
    string t;
    rst                 = s.rst;
    bus.id_valid        = s.valid;
    bus.id_rd           = s.rd;
    bus.id_reg_write    = s.rw;
    bus.id_is_load      = s.load;
    bus.id_rn           = s.rn;
    bus.id_rn_used      = s.rnu;
    bus.id_rm           = s.rm;
    bus.id_rm_used      = s.rmu;
    bus.id_halt         = s.halt;
    bus.ex_branch_taken = s.br;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.fwd_a,
           bus.fwd_b, bus.init_we, bus.init_addr, bus.halted};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    chk(t, 32'(got), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic run_init();
    for (int k = 0; k < NUM_REGS; k++) step($sformatf("init%0d", k), nop(), e_init(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    stim_t s;

    // Reset held with junk on ID: outputs must be the INIT/reset values.
    s = ins(5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
    s.rst = 1'b0; s.halt = 1'b1; s.br = 1'b1;
    step("reset", s, e_init(0));

    run_init();
    step("first_fetch", nop(), e_run(1, 1, 0, 0, 2'b00, 2'b00));

    // EX/MEM forward, then MEM/WB forward across a NOP.
    step("add_r3",   ins(5'd3, 1, 0, 5'd1, 1, 5'd2, 1), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("sub_ex",   ins(5'd5, 1, 0, 5'd3, 1, 5'd4, 1), e_run(1, 1, 0, 0, 2'b01, 2'b00));
    step("nop1",     nop(),                              e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("add_r6",   ins(5'd6, 1, 0, 5'd1, 1, 5'd2, 1), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("nop2",     nop(),                              e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("sub_mem",  ins(5'd9, 1, 0, 5'd6, 1, 5'd1, 1), e_run(1, 1, 0, 0, 2'b10, 2'b00));
    // Youngest producer wins; r0 is an ordinary register; unused operand.
    step("add_r9",   ins(5'd9, 1, 0, 5'd9, 1, 5'd9, 1), e_run(1, 1, 0, 0, 2'b01, 2'b01));
    step("youngest", ins(5'd10, 1, 0, 5'd9, 1, 5'd0, 1), e_run(1, 1, 0, 0, 2'b01, 2'b00));
    step("add_r0",   ins(5'd0, 1, 0, 5'd1, 1, 5'd2, 1), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("r0_fwd",   ins(5'd11, 1, 0, 5'd0, 1, 5'd0, 1), e_run(1, 1, 0, 0, 2'b01, 2'b01));
    step("unused",   ins(5'd13, 1, 0, 5'd11, 0, 5'd0, 1), e_run(1, 1, 0, 0, 2'b00, 2'b10));
    step("no_wr",    ins(5'd12, 0, 0, 5'd5, 1, 5'd6, 1), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("no_wr_use", ins(5'd14, 1, 0, 5'd12, 1, 5'd12, 1), e_run(1, 1, 0, 0, 2'b00, 2'b00));

    // Load-use: one stall, then both operands from MEM/WB.
    step("load_r7",  ins(5'd7, 1, 1, 5'd1, 1, 5'd0, 0), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    step("lu_stall", ins(5'd8, 1, 0, 5'd7, 1, 5'd7, 1), e_run(0, 0, 0, 1, 2'b00, 2'b00));
    step("lu_after", ins(5'd8, 1, 0, 5'd7, 1, 5'd7, 1), e_run(1, 1, 0, 0, 2'b10, 2'b10));

    // Taken branch beats a pending load-use stall.
    step("load_r15", ins(5'd15, 1, 1, 5'd1, 1, 5'd0, 0), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    s = ins(5'd16, 1, 0, 5'd15, 1, 5'd1, 1); s.br = 1'b1;
    step("br_vs_lu", s, e_run(1, 1, 1, 1, 2'b00, 2'b00));
    step("br_after", nop(), e_run(1, 1, 0, 0, 2'b00, 2'b00));

    // HALT squashed by a same-cycle taken branch: still running next cycle.
    s = ins(5'd0, 0, 0, 5'd0, 0, 5'd0, 0); s.halt = 1'b1; s.br = 1'b1;
    step("halt_br", s, e_run(1, 1, 1, 1, 2'b00, 2'b00));
    step("halt_br_run", nop(), e_run(1, 1, 0, 0, 2'b00, 2'b00));

    // HALT accepted: fetch stops next cycle, halted 4 cycles later.
    s = ins(5'd0, 0, 0, 5'd0, 0, 5'd0, 0); s.halt = 1'b1;
    step("halt_id", s, e_run(1, 1, 0, 1, 2'b00, 2'b00));
    step("drain0", s, e_stop(1'b0));
    step("drain1", s, e_stop(1'b0));
    step("drain2", s, e_stop(1'b0));
    step("halted",  s, e_stop(1'b1));
    step("halted_hold", nop(), e_stop(1'b1));

    // Reset from HALT, full re-clear, then reset in the middle of DRAIN.
    s = nop(); s.rst = 1'b0;
    step("rst_halt", s, e_init(0));
    run_init();
    step("refetch", nop(), e_run(1, 1, 0, 0, 2'b00, 2'b00));
    s = ins(5'd0, 0, 0, 5'd0, 0, 5'd0, 0); s.halt = 1'b1;
    step("halt2_id", s, e_run(1, 1, 0, 1, 2'b00, 2'b00));
    step("drain2_0", nop(), e_stop(1'b0));
    s = nop(); s.rst = 1'b0;
    step("rst_drain", s, e_init(0));
    step("rst_hold",  s, e_init(0));
    step("reinit0", nop(), e_init(0));
    step("reinit1", nop(), e_init(1));
    step("reinit2", nop(), e_init(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
